lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 84 ++++++++
 rtl/lsu_load_align.sv | 34 +++
 rtl/lsu_ctrl.sv | 124 ++++++++++++
 tb/tb_lsu_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: funct3 codes, FSM state
// encoding, op classification and store lane formatting.
package lsu_pkg;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_NONE = 3'b111;

  // Legacy state encodings kept so existing debug tooling decodes the same values.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_LOAD,
    OP_STORE,
    OP_ERR
  } op_kind_e;

  function automatic op_kind_e classify_op(input logic [2:0] ld_f3,
                                           input logic [2:0] st_f3,
                                           input logic [1:0] addr_lo);
    op_kind_e kind;
    kind = OP_ERR;
    if (ld_f3 == F3_NONE && st_f3 == F3_NONE) begin
      kind = OP_NOP;
    end else if (ld_f3 != F3_NONE && st_f3 != F3_NONE) begin
      kind = OP_ERR;
    end else if (ld_f3 != F3_NONE) begin
      case (ld_f3)
        F3_LB, F3_LBU: kind = OP_LOAD;
        F3_LH, F3_LHU: kind = addr_lo[0] ? OP_ERR : OP_LOAD;
        F3_LW:         kind = (addr_lo == 2'b00) ? OP_LOAD : OP_ERR;
        default:       kind = OP_ERR;
      endcase
    end else begin
      case (st_f3)
        F3_SB:   kind = OP_STORE;
        F3_SH:   kind = addr_lo[0] ? OP_ERR : OP_STORE;
        F3_SW:   kind = (addr_lo == 2'b00) ? OP_STORE : OP_ERR;
        default: kind = OP_ERR;
      endcase
    end
    return kind;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] st_f3, input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (st_f3)
      F3_SB:   mask = 4'b0001 << addr_lo;
      F3_SH:   mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_SW:   mask = 4'b1111;
      default: mask = '0;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] st_f3, input logic [31:0] wdata);
    logic [31:0] data;
    case (st_f3)
      F3_SB:   data = {4{wdata[7:0]}};
      F3_SH:   data = {2{wdata[15:0]}};
      F3_SW:   data = wdata;
      default: data = '0;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends
// it according to the load funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = addr_lo[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_LB:   result = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  result = {24'b0, byte_v};
      F3_LH:   result = {{16{half_v[15]}}, half_v};
      F3_LHU:  result = {16'b0, half_v};
      F3_LW:   result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one memory op at a time, runs a single
// request/response bus transaction with a WAIT timeout, and returns the result.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [2:0]  in_is_load,
  input  logic [2:0]  in_is_store,
  input  logic [31:0] in_wdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_e       state_q;
  logic [31:0]      addr_q;
  logic [2:0]       ld_f3_q;
  logic             mem_we_q;
  logic [31:0]      mem_wdata_q;
  logic [3:0]       mem_wmask_q;
  logic [31:0]      out_rdata_q;
  logic             out_err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  op_kind_e         op_kind;
  logic [31:0]      load_data;

  lsu_load_align u_load_align (
    .addr_lo (addr_q[1:0]),
    .funct3  (ld_f3_q),
    .word    (mem_rdata),
    .result  (load_data)
  );

  always_comb begin
    op_kind = classify_op(in_is_load, in_is_store, in_addr[1:0]);
    cnt_nxt = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      ld_f3_q     <= F3_NONE;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      out_rdata_q <= '0;
      out_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            addr_q      <= in_addr;
            ld_f3_q     <= in_is_load;
            mem_we_q    <= (op_kind == OP_STORE);
            mem_wmask_q <= (op_kind == OP_STORE) ? store_mask(in_is_store, in_addr[1:0]) : '0;
            mem_wdata_q <= (op_kind == OP_STORE) ? store_data(in_is_store, in_wdata) : '0;
            out_rdata_q <= '0;
            out_err_q   <= (op_kind == OP_ERR);
            cnt_q       <= '0;
            state_q     <= (op_kind == OP_LOAD || op_kind == OP_STORE) ? S_REQ : S_RESP;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // rvalid wins over a timeout landing in the same cycle
          if (mem_rvalid) begin
            out_rdata_q <= mem_we_q ? '0 : load_data;
            state_q     <= S_RESP;
          end else if (cnt_nxt == TIMEOUT_VAL) begin
            cnt_q       <= cnt_nxt;
            out_rdata_q <= '0;
            out_err_q   <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_nxt;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign out_valid = (state_q == S_RESP);
  assign out_rdata = out_rdata_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed ops push expected bus requests and
// responses; negedge monitors pop and compare when the DUT presents them.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [2:0]  in_is_load;
  logic [2:0]  in_is_store;
  logic [31:0] in_wdata;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_is_load  (in_is_load),
    .in_is_store (in_is_store),
    .in_wdata    (in_wdata),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rdata   (out_rdata),
    .out_err     (out_err)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got rdata %h err %b expected no response", out_rdata, out_err);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        check("resp_rdata", out_rdata, e.rdata);
        check("resp_err", {31'b0, out_err}, {31'b0, e.err});
      end
    end
    if (!rst && mem_req) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got mem_req=1 addr %h expected no request", mem_addr);
      end else if (mem_gnt) begin
        bus_t b;
        b = bus_q.pop_front();
        check("bus_we", {31'b0, mem_we}, {31'b0, b.we});
        check("bus_addr", mem_addr, b.addr);
        check("bus_wmask", {28'b0, mem_wmask}, {28'b0, b.wmask});
        if (b.we) check("bus_wdata", mem_wdata, b.wdata);
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "/in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string nm, input logic [2:0] ld, input logic [2:0] st,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input bit bus, input int gnt_wait, input int rv_wait, input int rdy_wait,
                        input bit late_rv, input logic [31:0] exp_rdata, input bit exp_err,
                        input logic [3:0] exp_mask, input logic [31:0] exp_wdata, input int exp_lat);
    int   t0;
    int   n;
    bus_t b;
    logic exp_we;
    exp_we = (st != F3_NONE);
    wait_idle(nm);
    resp_q.push_back({exp_rdata, exp_err});
    b.we    = exp_we;
    b.addr  = {addr[31:2], 2'b00};
    b.wdata = exp_wdata;
    b.wmask = exp_mask;
    if (bus) bus_q.push_back(b);
    in_valid    = 1'b1;
    in_is_load  = ld;
    in_is_store = st;
    in_addr     = addr;
    in_wdata    = wdata;
    t0 = cyc;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    in_is_load  = F3_NONE;
    in_is_store = F3_NONE;
    in_wdata    = 32'h5555_AAAA;
    if (bus) begin
      for (int i = 0; i < gnt_wait; i++) begin
        check({nm, "/hold_req"}, {31'b0, mem_req}, 32'd1);
        check({nm, "/hold_addr"}, mem_addr, b.addr);
        check({nm, "/hold_mask"}, {28'b0, mem_wmask}, {28'b0, exp_mask});
        if (exp_we) check({nm, "/hold_wdata"}, mem_wdata, exp_wdata);
        @(posedge clk); #1;
      end
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      if (rv_wait >= 0) begin
        for (int i = 0; i < rv_wait; i++) begin
          @(posedge clk); #1;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0BAD_0BAD;
      end
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "/out_valid"}, {31'b0, out_valid}, 32'd1);
    if (exp_lat >= 0) check({nm, "/latency"}, cyc - t0, exp_lat);
    for (int i = 0; i < rdy_wait; i++) begin
      check({nm, "/hold_valid"}, {31'b0, out_valid}, 32'd1);
      check({nm, "/hold_rdata"}, out_rdata, exp_rdata);
      check({nm, "/hold_err"}, {31'b0, out_err}, {31'b0, exp_err});
      mem_rvalid = late_rv;
      mem_rdata  = 32'hFFFF_FFFF;
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "/back_idle"}, {30'b0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_addr     = '0;
    in_is_load  = F3_NONE;
    in_is_store = F3_NONE;
    in_wdata    = '0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    out_ready   = 1'b0;
    #1;
    check("rst/in_ready", {31'b0, in_ready}, 32'd1);
    check("rst/mem_req", {31'b0, mem_req}, 32'd0);
    check("rst/mem_we", {31'b0, mem_we}, 32'd0);
    check("rst/mem_addr", mem_addr, 32'd0);
    check("rst/mem_wdata", mem_wdata, 32'd0);
    check("rst/mem_wmask", {28'b0, mem_wmask}, 32'd0);
    check("rst/out_valid", {31'b0, out_valid}, 32'd0);
    check("rst/out_rdata", out_rdata, 32'd0);
    check("rst/out_err", {31'b0, out_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check("stray/idle", {29'b0, in_ready, mem_req, out_valid}, 32'd4);

    //     name        ld      st       addr           wdata          rdata          bus gw rv rdy late exp_rdata      err mask     exp_wdata      lat
    run_op("lb",      F3_LB,   F3_NONE, 32'h8000_0003, 32'h0,         32'h80FF_1234, 1, 0, 0, 0, 0, 32'hFFFF_FF80, 0, 4'b0000, 32'h0,         3);
    run_op("sh",      F3_NONE, F3_SH,   32'h8000_0002, 32'h0000_BEEF, 32'h1357_9BDF, 1, 0, 0, 0, 0, 32'h0,         0, 4'b1100, 32'hBEEF_BEEF, 3);
    run_op("lw_mis",  F3_LW,   F3_NONE, 32'h8000_0001, 32'h0,         32'h0,         0, 0, 0, 0, 0, 32'h0,         1, 4'b0000, 32'h0,         1);
    run_op("lhu",     F3_LHU,  F3_NONE, 32'h8000_0000, 32'h0,         32'hABCD_1234, 1, 5, 0, 3, 0, 32'h0000_1234, 0, 4'b0000, 32'h0,         8);
    run_op("lw_to",   F3_LW,   F3_NONE, 32'h8000_0004, 32'h0,         32'h0,         1, 0,-1, 3, 1, 32'h0,         1, 4'b0000, 32'h0,         6);
    run_op("sb",      F3_NONE, F3_SB,   32'h1000_0001, 32'h1234_56A5, 32'h0,         1, 1, 1, 0, 0, 32'h0,         0, 4'b0010, 32'hA5A5_A5A5, 5);
    run_op("sw",      F3_NONE, F3_SW,   32'h2000_0000, 32'hDEAD_BEEF, 32'h0,         1, 0, 0, 1, 0, 32'h0,         0, 4'b1111, 32'hDEAD_BEEF, 3);
    run_op("lh",      F3_LH,   F3_NONE, 32'h0000_0002, 32'h0,         32'h8001_7FFF, 1, 0, 0, 0, 0, 32'hFFFF_8001, 0, 4'b0000, 32'h0,         3);
    run_op("lbu",     F3_LBU,  F3_NONE, 32'h0000_0001, 32'h0,         32'h1234_9A78, 1, 0, 0, 0, 0, 32'h0000_009A, 0, 4'b0000, 32'h0,         3);
    run_op("lw",      F3_LW,   F3_NONE, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 1, 0, 2, 0, 0, 32'hCAFE_F00D, 0, 4'b0000, 32'h0,         5);
    run_op("nop",     F3_NONE, F3_NONE, 32'h0000_0010, 32'h0,         32'h0,         0, 0, 0, 1, 0, 32'h0,         0, 4'b0000, 32'h0,         1);
    run_op("both",    F3_LB,   F3_SB,   32'h0000_0010, 32'h0,         32'h0,         0, 0, 0, 0, 0, 32'h0,         1, 4'b0000, 32'h0,         1);
    run_op("ld_ill",  3'b011,  F3_NONE, 32'h0000_0010, 32'h0,         32'h0,         0, 0, 0, 0, 0, 32'h0,         1, 4'b0000, 32'h0,         1);
    run_op("st_ill",  F3_NONE, 3'b011,  32'h0000_0010, 32'h0,         32'h0,         0, 0, 0, 0, 0, 32'h0,         1, 4'b0000, 32'h0,         1);
    run_op("sh_mis",  F3_NONE, F3_SH,   32'h0000_0003, 32'h1111_2222, 32'h0,         0, 0, 0, 0, 0, 32'h0,         1, 4'b0000, 32'h0,         1);
    run_op("sw_mis",  F3_NONE, F3_SW,   32'h0000_0002, 32'h1111_2222, 32'h0,         0, 0, 0, 0, 0, 32'h0,         1, 4'b0000, 32'h0,         1);

    // Reset while an LW sits in WAIT: the access is dropped with no response.
    wait_idle("rst_wait");
    bus_q.push_back({1'b0, 32'h0000_0100, 32'h0, 4'b0000});
    in_valid   = 1'b1;
    in_is_load = F3_LW;
    in_addr    = 32'h0000_0100;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_is_load = F3_NONE;
    mem_gnt    = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("rst_wait/busy", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("rst_wait/mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_wait/out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_wait/in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("rst_wait/no_resp", {31'b0, out_valid}, 32'd0);
    run_op("post_rst", F3_LW,  F3_NONE, 32'h0000_0200, 32'h0, 32'h0123_4567, 1, 0, 0, 0, 0, 32'h0123_4567, 0, 4'b0000, 32'h0, 3);

    repeat (2) @(posedge clk);
    #1;
    check("drain/resp_q", resp_q.size(), 32'd0);
    check("drain/bus_q", bus_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
